// File: rtl/fcvt_arbiter.sv
// fcvt_arbiter: shares one int-to-single converter (fcvt.s.w) between two
// requesters with round-robin arbitration and valid/ready handshakes.
// One operation is outstanding at a time. The converter is expected to present
// its result CVT_LAT cycles after cvt_rs1 becomes stable.
// Optional feature macro: FCVT_ARB_ZERO_BYPASS_EN -- when defined, an accepted
// operand of exactly 32'h00000000 is answered on the accept edge with +0.0.
module fcvt_arbiter #(
    parameter int CVT_LAT = 1,
    parameter int TAG_W   = 5
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [63:0]          req_rs1,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic [31:0]          cvt_rs1,
    input  logic [31:0]          cvt_out,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [31:0]          resp_data,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preload: the capture edge is CVT_LAT edges after the accept edge.
    localparam logic [3:0] LAT_M1 = 4'(CVT_LAT - 1);

    state_t               state_r;
    logic                 rr_ptr_r;
    logic                 owner_r;
    logic [3:0]           counter_r;
    logic [31:0]          cvt_rs1_r;
    logic [31:0]          resp_data_r;
    logic [TAG_W-1:0]     resp_tag_r;
    logic [1:0]           resp_valid_r;
    logic                 busy_r;

    logic                 grant_s;
    logic [1:0]           req_ready_s;
    logic                 accept_s;
    logic [31:0]          sel_rs1_s;
    logic [TAG_W-1:0]     sel_tag_s;

    // Round-robin grant: a lone requester wins, a tie goes to rr_ptr.
    always_comb begin
        grant_s = rr_ptr_r;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = rr_ptr_r;
            default: grant_s = rr_ptr_r;
        endcase
    end

    // Ready is offered only in IDLE and only to the granted requester.
    always_comb begin
        req_ready_s = 2'b00;
        if (state_r == IDLE) begin
            req_ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign accept_s  = |(req_valid & req_ready_s);
    assign sel_rs1_s = grant_s ? req_rs1[63:32] : req_rs1[31:0];
    assign sel_tag_s = grant_s ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

    // Arbitration FSM: accept, wait out converter latency, hold response until taken.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_r      <= IDLE;
            rr_ptr_r     <= 1'b0;
            owner_r      <= 1'b0;
            counter_r    <= 4'd0;
            cvt_rs1_r    <= 32'd0;
            resp_data_r  <= 32'd0;
            resp_tag_r   <= {TAG_W{1'b0}};
            resp_valid_r <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cvt_rs1_r  <= sel_rs1_s;
                        resp_tag_r <= sel_tag_s;
                        owner_r    <= grant_s;
                        rr_ptr_r   <= ~grant_s;
                        counter_r  <= LAT_M1;
                        busy_r     <= 1'b1;
`ifdef FCVT_ARB_ZERO_BYPASS_EN
                        // +0 needs no conversion; -2^31 (32'h80000000) is not zero.
                        if (sel_rs1_s == 32'h0000_0000) begin
                            resp_data_r  <= 32'h0000_0000;
                            resp_valid_r <= grant_s ? 2'b10 : 2'b01;
                            state_r      <= RESP;
                        end else begin
                            state_r <= BUSY;
                        end
`else
                        state_r <= BUSY;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (counter_r == 4'd0) begin
                        resp_data_r  <= cvt_out;
                        resp_valid_r <= owner_r ? 2'b10 : 2'b01;
                        state_r      <= RESP;
                    end else begin
                        counter_r <= counter_r - 4'd1;
                    end
                end
                RESP: begin
                    // Only the owner's resp_ready completes the handshake.
                    if (resp_ready[owner_r]) begin
                        resp_valid_r <= 2'b00;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 2'b00;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign cvt_rs1    = cvt_rs1_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_tag   = resp_tag_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Directed bench for fcvt_arbiter. Two instances: index 0 has CVT_LAT=1,
// index 1 has CVT_LAT=4. A combinational int-to-float model stands in for the
// shared converter; all expected results are hand-computed constants.
module tb_fcvt_arbiter;

    localparam int TAG_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn     [2];
    logic [1:0]          req_valid  [2];
    logic [1:0]          req_ready  [2];
    logic [63:0]         req_rs1    [2];
    logic [2*TAG_W-1:0]  req_tag    [2];
    logic [31:0]         cvt_rs1    [2];
    logic [31:0]         cvt_out    [2];
    logic [1:0]          resp_valid [2];
    logic [1:0]          resp_ready [2];
    logic [31:0]         resp_data  [2];
    logic [TAG_W-1:0]    resp_tag   [2];
    logic                busy       [2];

    int n_cmp = 0;
    int n_err = 0;

    // Signed 32-bit integer to IEEE-754 single, round to nearest even.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [31:0] m;
        logic [31:0] mant;
        logic [31:0] rem;
        logic [31:0] half;
        int          msb;
        int          sh;
        if (x == 32'd0) return 32'd0;
        s   = x[31];
        m   = s ? (~x + 32'd1) : x;
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        if (msb <= 23) begin
            mant = m << (23 - msb);
        end else begin
            sh   = msb - 23;
            mant = m >> sh;
            rem  = m & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                msb  = msb + 1;
            end
        end
        return {s, 8'(msb + 127), mant[22:0]};
    endfunction

    assign cvt_out[0] = i2f(cvt_rs1[0]);
    assign cvt_out[1] = i2f(cvt_rs1[1]);

    fcvt_arbiter #(.CVT_LAT(1), .TAG_W(TAG_W)) u_lat1 (
        .clk(clk), .resetn(resetn[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_rs1(req_rs1[0]), .req_tag(req_tag[0]),
        .cvt_rs1(cvt_rs1[0]), .cvt_out(cvt_out[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_tag(resp_tag[0]), .busy(busy[0])
    );

    fcvt_arbiter #(.CVT_LAT(4), .TAG_W(TAG_W)) u_lat4 (
        .clk(clk), .resetn(resetn[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_rs1(req_rs1[1]), .req_tag(req_tag[1]),
        .cvt_rs1(cvt_rs1[1]), .cvt_out(cvt_out[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_tag(resp_tag[1]), .busy(busy[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [1:0] v, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [TAG_W-1:0] t0,
                         input logic [TAG_W-1:0] t1);
        req_valid[d] = v;
        req_rs1[d]   = {a1, a0};
        req_tag[d]   = {t1, t0};
        #1;
    endtask

    task automatic idle(input int d);
        req_valid[d] = 2'b00;
        #1;
    endtask

    task automatic chk_resp(input int d, input string tag, input logic [1:0] v,
                            input logic [31:0] data, input logic [TAG_W-1:0] t);
        chk({tag, "_valid"}, 64'(resp_valid[d]), 64'(v));
        chk({tag, "_data"},  64'(resp_data[d]),  64'(data));
        chk({tag, "_tag"},   64'(resp_tag[d]),   64'(t));
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, "_cvt_rs1"},    64'(cvt_rs1[d]),    64'd0);
        chk({tag, "_resp_data"},  64'(resp_data[d]),  64'd0);
        chk({tag, "_resp_tag"},   64'(resp_tag[d]),   64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid[d]), 64'd0);
        chk({tag, "_busy"},       64'(busy[d]),       64'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            resetn[d]     = 1'b1;
            req_valid[d]  = 2'b00;
            req_rs1[d]    = 64'd0;
            req_tag[d]    = '0;
            resp_ready[d] = 2'b00;
        end
        tick();
        tick();
        chk_reset(0, "rst_lat1");
        chk_reset(1, "rst_lat4");
        resetn[0]     = 1'b0;
        resetn[1]     = 1'b0;
        resp_ready[0] = 2'b11;
        resp_ready[1] = 2'b11;

        // Single request, CVT_LAT=1: rs1=5 -> 5.0
        drive(0, 2'b01, 32'd5, 32'd0, 5'd3, 5'd0);
        chk("t1_ready_idle", 64'(req_ready[0]), 64'h1);
        tick();
        idle(0);
        chk("t1_busy",       64'(busy[0]),      64'd1);
        chk("t1_cvt_rs1",    64'(cvt_rs1[0]),   64'd5);
        chk("t1_no_resp",    64'(resp_valid[0]), 64'd0);
        chk("t1_ready_busy", 64'(req_ready[0]), 64'd0);
        tick();
        chk_resp(0, "t1_resp", 2'b01, 32'h40A0_0000, 5'd3);
        drive(0, 2'b01, 32'd9, 32'd0, 5'd1, 5'd0);
        chk("t1_ready_resp", 64'(req_ready[0]), 64'd0);
        tick();
        chk("t1_ready_back", 64'(req_ready[0]), 64'h1);
        chk("t1_valid_low",  64'(resp_valid[0]), 64'd0);
        chk("t1_busy_low",   64'(busy[0]),      64'd0);
        idle(0);

        // Simultaneous requests after reset: 0 first, then 1, then 0 again
        resetn[0] = 1'b1;
        tick();
        resetn[0] = 1'b0;
        drive(0, 2'b11, 32'd1, 32'hFFFF_FFFF, 5'd1, 5'd2);
        chk("t2_grant0", 64'(req_ready[0]), 64'h1);
        tick();
        drive(0, 2'b10, 32'd1, 32'hFFFF_FFFF, 5'd1, 5'd2);
        tick();
        chk_resp(0, "t2_resp0", 2'b01, 32'h3F80_0000, 5'd1);
        tick();
        chk("t2_grant1", 64'(req_ready[0]), 64'h2);
        tick();
        idle(0);
        chk("t2_busy1",  64'(busy[0]),     64'd1);
        chk("t2_tag1",   64'(resp_tag[0]), 64'd2);
        tick();
        chk_resp(0, "t2_resp1", 2'b10, 32'hBF80_0000, 5'd2);
        tick();
        drive(0, 2'b11, 32'd1, 32'hFFFF_FFFF, 5'd1, 5'd2);
        chk("t2_regrant0", 64'(req_ready[0]), 64'h1);
        tick();
        idle(0);
        chk("t2_tag0_again", 64'(resp_tag[0]), 64'd1);
        tick();
        chk_resp(0, "t2_resp0_again", 2'b01, 32'h3F80_0000, 5'd1);
        tick();

        // Latency parameter, CVT_LAT=4: requester 1 rs1=-8 -> -8.0
        drive(1, 2'b10, 32'd0, 32'hFFFF_FFF8, 5'd0, 5'd9);
        chk("t3_grant1", 64'(req_ready[1]), 64'h2);
        tick();
        idle(1);
        chk("t3_wait0", 64'(resp_valid[1]), 64'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("t3_wait%0d", k), 64'(resp_valid[1]), 64'd0);
        end
        tick();
        chk_resp(1, "t3_resp", 2'b10, 32'hC100_0000, 5'd9);
        tick();

        // Response backpressure on CVT_LAT=1 instance
        resp_ready[0] = 2'b00;
        drive(0, 2'b01, 32'd2, 32'd3, 5'd4, 5'd6);
        chk("t4_grant0", 64'(req_ready[0]), 64'h1);
        tick();
        drive(0, 2'b10, 32'd2, 32'd3, 5'd4, 5'd6);
        tick();
        resp_ready[0] = 2'b10;
        for (int k = 0; k < 5; k++) begin
            chk_resp(0, $sformatf("t4_hold%0d", k), 2'b01, 32'h4000_0000, 5'd4);
            chk($sformatf("t4_ready%0d", k), 64'(req_ready[0]), 64'd0);
            chk($sformatf("t4_busy%0d", k),  64'(busy[0]),      64'd1);
            tick();
        end
        chk_resp(0, "t4_hold_end", 2'b01, 32'h4000_0000, 5'd4);
        resp_ready[0] = 2'b11;
        tick();
        chk("t4_ready_after", 64'(req_ready[0]), 64'h2);
        chk("t4_valid_after", 64'(resp_valid[0]), 64'd0);
        tick();
        idle(0);
        chk("t4_next_busy", 64'(busy[0]),     64'd1);
        chk("t4_next_rs1",  64'(cvt_rs1[0]),  64'd3);
        chk("t4_next_tag",  64'(resp_tag[0]), 64'd6);
        tick();
        chk_resp(0, "t4_next_resp", 2'b10, 32'h4040_0000, 5'd6);
        tick();

        // Reset mid-operation on CVT_LAT=4 instance
        drive(1, 2'b01, 32'd7, 32'd0, 5'd5, 5'd0);
        tick();
        idle(1);
        tick();
        tick();
        resetn[1] = 1'b1;
        tick();
        resetn[1] = 1'b0;
        chk_reset(1, "t5_rst");
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t5_no_resp%0d", k), 64'(resp_valid[1]), 64'd0);
        end
        drive(1, 2'b11, 32'd1, 32'd3, 5'd1, 5'd2);
        chk("t5_grant0", 64'(req_ready[1]), 64'h1);
        tick();
        idle(1);
        chk("t5_rs1", 64'(cvt_rs1[1]), 64'd1);
        repeat (3) tick();
        tick();
        chk_resp(1, "t5_resp", 2'b01, 32'h3F80_0000, 5'd1);
        tick();

        // Zero operand on CVT_LAT=4 instance
        drive(1, 2'b01, 32'd0, 32'd0, 5'd7, 5'd0);
        tick();
        idle(1);
        chk("t6_rs1", 64'(cvt_rs1[1]),  64'd0);
        chk("t6_tag", 64'(resp_tag[1]), 64'd7);
`ifdef FCVT_ARB_ZERO_BYPASS_EN
        chk_resp(1, "t6_bypass", 2'b01, 32'h0000_0000, 5'd7);
`else
        chk("t6_wait0", 64'(resp_valid[1]), 64'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("t6_wait%0d", k), 64'(resp_valid[1]), 64'd0);
        end
        tick();
        chk_resp(1, "t6_resp", 2'b01, 32'h0000_0000, 5'd7);
`endif
        tick();

        // Most negative integer never takes the zero path: -2^31 -> 32'hCF000000
        drive(1, 2'b10, 32'd0, 32'h8000_0000, 5'd0, 5'd8);
        tick();
        idle(1);
        chk("t7_wait0", 64'(resp_valid[1]), 64'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("t7_wait%0d", k), 64'(resp_valid[1]), 64'd0);
        end
        tick();
        chk_resp(1, "t7_resp", 2'b10, 32'hCF00_0000, 5'd8);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
